mini_mips_pc_sequencer: RTL and testbench

//   Program-counter sequencer that sits directly upstream of MiniMIPS.

---
 rtl/mini_mips_pc_sequencer.sv | 122 ++++++++++++
 tb/tb_mini_mips_pc_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mini_mips_pc_sequencer.sv
// PC sequencer feeding MiniMIPS: registers pc_new, captures pc_next, and adds
// stall/restart control, halt detection and saturating run statistics.
module mini_mips_pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_ADDR  = 32'h0000_0023,
  parameter logic [31:0] PC_STEP    = 32'd1,
  parameter int          LOOP_LIMIT = 8,
  parameter int          MAX_CYCLES = 4096,
  parameter int          CNT_W      = 16
) (
  input  logic             pc_clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_next,
  input  logic             stall,
  input  logic             restart,
  output logic [31:0]      pc_new,
  output logic             pc_valid,
  output logic             halted,
  output logic [1:0]       halt_reason,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] branch_count
);

  localparam int LOOP_W = $clog2(LOOP_LIMIT) + 1;
  localparam int CYC_W  = $clog2(MAX_CYCLES) + 1;

  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [1:0]        reason_q, reason_d;
  logic [CNT_W-1:0]  instr_q, instr_d, branch_q, branch_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;

  logic at_end, self_loop, loop_hit, timeout, seq_step;

  assign at_end    = (pc_q == HALT_ADDR);
  assign self_loop = (pc_next == pc_q);
  assign loop_hit  = self_loop && (loop_q == LOOP_W'(LOOP_LIMIT - 1));
  assign timeout   = (cyc_q == CYC_W'(MAX_CYCLES - 1));
  // 32-bit wrapping add, so FFFF_FFFF -> 0 counts as sequential
  assign seq_step  = (pc_next == pc_q + PC_STEP);

  always_ff @(posedge pc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      pc_q     <= RESET_PC;
      reason_q <= 2'b00;
      instr_q  <= '0;
      branch_q <= '0;
      loop_q   <= '0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      reason_q <= reason_d;
      instr_q  <= instr_d;
      branch_q <= branch_d;
      loop_q   <= loop_d;
      cyc_q    <= cyc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    reason_d = reason_q;
    instr_d  = instr_q;
    branch_d = branch_q;
    loop_d   = loop_q;
    cyc_d    = cyc_q;
    if (restart) begin
      state_d  = INIT;
      pc_d     = RESET_PC;
      reason_d = 2'b00;
      instr_d  = '0;
      branch_d = '0;
      loop_d   = '0;
      cyc_d    = '0;
    end else begin
      case (state_q)
        INIT: state_d = RUN;
        RUN: begin
          cyc_d = cyc_q + CYC_W'(1);
          if (at_end) begin
            state_d  = HALT;
            reason_d = 2'b01;
          end else if (stall) begin
            if (timeout) begin
              state_d  = HALT;
              reason_d = 2'b11;
            end
          end else if (loop_hit) begin
            state_d  = HALT;
            reason_d = 2'b10;
          end else if (timeout) begin
            state_d  = HALT;
            reason_d = 2'b11;
          end else begin
            pc_d = pc_next;
            if (instr_q != '1) instr_d = instr_q + CNT_W'(1);
            if (!seq_step && branch_q != '1) branch_d = branch_q + CNT_W'(1);
            loop_d = self_loop ? loop_q + LOOP_W'(1) : '0;
          end
        end
        HALT: state_d = HALT;
        default: state_d = INIT;
      endcase
    end
  end

  always_comb begin
    pc_valid     = (state_q == RUN);
    halted       = (state_q == HALT);
    pc_new       = pc_q;
    halt_reason  = reason_q;
    instr_count  = instr_q;
    branch_count = branch_q;
  end

endmodule

// File: tb/tb_mini_mips_pc_sequencer.sv
// Directed bench for mini_mips_pc_sequencer: instance a (LOOP_LIMIT=4) covers
// run/branch/stall/loop/restart/wrap, instance b (MAX_CYCLES=16) covers timeout.
module tb_mini_mips_pc_sequencer;

  logic        pc_clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_next, pc_new;
  logic        stall, restart, pc_valid, halted;
  logic [1:0]  halt_reason;
  logic [15:0] instr_count, branch_count;
  logic        fix_en;
  logic [31:0] fix_val;

  logic [31:0] b_pc_next, b_pc_new;
  logic        b_stall, b_restart, b_pc_valid, b_halted;
  logic [1:0]  b_halt_reason;
  logic [15:0] b_instr_count, b_branch_count;

  int errors = 0;
  int checks = 0;

  always #5 pc_clk = ~pc_clk;

  // datapath stand-in: sequential next PC unless a fixed target is forced
  assign pc_next   = fix_en ? fix_val : pc_new + 32'd1;
  assign b_pc_next = b_pc_new + 32'd1;

  mini_mips_pc_sequencer #(.LOOP_LIMIT(4)) dut_a (
    .pc_clk(pc_clk), .rst_n(rst_n), .pc_next(pc_next), .stall(stall),
    .restart(restart), .pc_new(pc_new), .pc_valid(pc_valid), .halted(halted),
    .halt_reason(halt_reason), .instr_count(instr_count), .branch_count(branch_count)
  );

  mini_mips_pc_sequencer #(.MAX_CYCLES(16)) dut_b (
    .pc_clk(pc_clk), .rst_n(rst_n), .pc_next(b_pc_next), .stall(b_stall),
    .restart(b_restart), .pc_new(b_pc_new), .pc_valid(b_pc_valid), .halted(b_halted),
    .halt_reason(b_halt_reason), .instr_count(b_instr_count), .branch_count(b_branch_count)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge pc_clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++; if (pc_new !== 32'h0 || pc_valid !== 1'b0 || halted !== 1'b0 || halt_reason !== 2'b00) begin
      errors++; $display("FAIL reset_state: pc=%h valid=%b halted=%b reason=%b, want 0/0/0/00", pc_new, pc_valid, halted, halt_reason); end
    @(negedge pc_clk); rst_n = 1'b1;
    #1;
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL init_valid: got %b want 0", pc_valid); end
    tick();
    checks++; if (pc_valid !== 1'b1 || pc_new !== 32'h0) begin
      errors++; $display("FAIL first_run: valid=%b pc=%h want 1/0", pc_valid, pc_new); end
    tick(9);
    checks++; if (pc_new !== 32'h9 || instr_count !== 16'd9) begin
      errors++; $display("FAIL run_to_9: pc=%h instr=%0d want 9/9", pc_new, instr_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc_new !== 32'h0 || pc_valid !== 1'b0 || halted !== 1'b0 || instr_count !== 16'd0 || branch_count !== 16'd0) begin
      errors++; $display("FAIL async_reset: pc=%h valid=%b halted=%b instr=%0d br=%0d want 0/0/0/0/0", pc_new, pc_valid, halted, instr_count, branch_count); end
    #1 rst_n = 1'b1;
    tick();
    checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid: got %b want 1", pc_valid); end
  endtask

  task automatic test_run_to_end;
    tick(35);
    checks++; if (pc_new !== 32'h23 || instr_count !== 16'd35 || halted !== 1'b0) begin
      errors++; $display("FAIL reach_end: pc=%h instr=%0d halted=%b want 23/35/0", pc_new, instr_count, halted); end
    tick();
    checks++; if (halted !== 1'b1 || halt_reason !== 2'b01 || pc_new !== 32'h23 || instr_count !== 16'd35 || branch_count !== 16'd0 || pc_valid !== 1'b0) begin
      errors++; $display("FAIL end_halt: halted=%b reason=%b pc=%h instr=%0d br=%0d valid=%b want 1/01/23/35/0/0",
                         halted, halt_reason, pc_new, instr_count, branch_count, pc_valid); end
    tick(3);
    checks++; if (halted !== 1'b1 || pc_new !== 32'h23 || instr_count !== 16'd35) begin
      errors++; $display("FAIL halt_frozen: halted=%b pc=%h instr=%0d want 1/23/35", halted, pc_new, instr_count); end
  endtask

  task automatic test_restart_halt;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++; if (pc_new !== 32'h0 || halted !== 1'b0 || pc_valid !== 1'b0 || halt_reason !== 2'b00 || instr_count !== 16'd0) begin
      errors++; $display("FAIL restart_from_halt: pc=%h halted=%b valid=%b reason=%b instr=%0d want 0/0/0/00/0",
                         pc_new, halted, pc_valid, halt_reason, instr_count); end
    tick();
    checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL restart_init_len: valid=%b want 1", pc_valid); end
  endtask

  task automatic test_branch;
    tick(5);
    fix_en = 1'b1; fix_val = 32'h10;
    tick();
    fix_en = 1'b0;
    checks++; if (pc_new !== 32'h10 || branch_count !== 16'd1 || instr_count !== 16'd6) begin
      errors++; $display("FAIL branch: pc=%h br=%0d instr=%0d want 10/1/6", pc_new, branch_count, instr_count); end
  endtask

  task automatic test_stall;
    restart = 1'b1; tick(); restart = 1'b0;
    tick();
    tick(4);
    stall = 1'b1;
    tick(3);
    checks++; if (pc_new !== 32'h4 || instr_count !== 16'd4) begin
      errors++; $display("FAIL stall_hold: pc=%h instr=%0d want 4/4", pc_new, instr_count); end
    stall = 1'b0;
    tick();
    checks++; if (pc_new !== 32'h5 || instr_count !== 16'd5) begin
      errors++; $display("FAIL stall_release: pc=%h instr=%0d want 5/5", pc_new, instr_count); end
  endtask

  task automatic test_loop;
    tick(2);
    fix_en = 1'b1; fix_val = 32'h7;
    tick(3);
    checks++; if (pc_new !== 32'h7 || halted !== 1'b0 || instr_count !== 16'd10 || branch_count !== 16'd3) begin
      errors++; $display("FAIL loop_count: pc=%h halted=%b instr=%0d br=%0d want 7/0/10/3", pc_new, halted, instr_count, branch_count); end
    tick();
    checks++; if (halted !== 1'b1 || halt_reason !== 2'b10 || pc_new !== 32'h7 || instr_count !== 16'd10) begin
      errors++; $display("FAIL loop_halt: halted=%b reason=%b pc=%h instr=%0d want 1/10/7/10", halted, halt_reason, pc_new, instr_count); end
    fix_en = 1'b0;
  endtask

  task automatic test_restart_stall;
    restart = 1'b1; tick(); restart = 1'b0;
    tick(10);
    checks++; if (pc_new !== 32'h9) begin errors++; $display("FAIL pre_restart_pc: got %h want 9", pc_new); end
    stall = 1'b1; restart = 1'b1;
    tick();
    stall = 1'b0; restart = 1'b0;
    checks++; if (pc_new !== 32'h0 || instr_count !== 16'd0 || branch_count !== 16'd0 || pc_valid !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL restart_over_stall: pc=%h instr=%0d br=%0d valid=%b halted=%b want 0/0/0/0/0",
                         pc_new, instr_count, branch_count, pc_valid, halted); end
  endtask

  task automatic test_wrap;
    tick();
    fix_en = 1'b1; fix_val = 32'hFFFF_FFFF;
    tick();
    fix_en = 1'b0;
    tick();
    checks++; if (pc_new !== 32'h0 || branch_count !== 16'd1 || instr_count !== 16'd2) begin
      errors++; $display("FAIL pc_wrap: pc=%h br=%0d instr=%0d want 0/1/2", pc_new, branch_count, instr_count); end
  endtask

  task automatic test_timeout;
    b_stall = 1'b1; b_restart = 1'b0;
    tick();
    checks++; if (b_pc_valid !== 1'b1) begin errors++; $display("FAIL b_run: valid=%b want 1", b_pc_valid); end
    tick(15);
    checks++; if (b_halted !== 1'b0 || b_pc_valid !== 1'b1) begin
      errors++; $display("FAIL timeout_early: halted=%b valid=%b want 0/1", b_halted, b_pc_valid); end
    tick();
    checks++; if (b_halted !== 1'b1 || b_halt_reason !== 2'b11 || b_pc_new !== 32'h0 || b_instr_count !== 16'd0) begin
      errors++; $display("FAIL timeout_halt: halted=%b reason=%b pc=%h instr=%0d want 1/11/0/0", b_halted, b_halt_reason, b_pc_new, b_instr_count); end
  endtask

  initial begin
    stall = 1'b0; restart = 1'b0; fix_en = 1'b0; fix_val = 32'h0;
    b_stall = 1'b0; b_restart = 1'b1;
    test_reset();
    test_run_to_end();
    test_restart_halt();
    test_branch();
    test_stall();
    test_loop();
    test_restart_stall();
    test_wrap();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
